// File: rtl/md_sched_if.sv
// Pipeline-side bundle for the multiply/divide scheduler: E-stage op and operands,
// D-stage HI/LO usage, and the HI/LO, busy and stall results.
interface md_sched_if;
    logic [2:0]  md_op_E;
    logic [31:0] A_E;
    logic [31:0] B_E;
    logic        md_use_D;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        start;
    logic        stall_md;

    modport master (
        output md_op_E, A_E, B_E, md_use_D,
        input  HI, LO, busy, start, stall_md
    );

    modport slave (
        input  md_op_E, A_E, B_E, md_use_D,
        output HI, LO, busy, start, stall_md
    );
endinterface

// File: rtl/md_sched.sv
// Fixed-latency multiply/divide controller beside EX: owns HI/LO, runs the busy
// window and raises stall_md for D-stage HI/LO users while starting or busy.
//
// state | meaning
// IDLE  | accepts mult/multu/div/divu (start) and mthi/mtlo (direct write)
// BUSY  | result held in hi_n/lo_n; cnt counts down to commit on cnt==1
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic        clk,
    input logic        reset,
    md_sched_if.slave  md
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic [31:0] hi_q, lo_q;
    logic [31:0] hi_n, lo_n;
    logic [31:0] res_hi, res_lo;
    logic        is_md;
    logic [63:0] prod;
    logic [31:0] mag_a, mag_b, quo, rem;

    assign is_md       = (md.md_op_E >= OP_MULT) && (md.md_op_E <= OP_DIVU);
    assign md.start    = is_md && (state == IDLE);
    assign md.busy     = (state == BUSY);
    assign md.stall_md = md.md_use_D && (md.start || md.busy);
    assign md.HI       = hi_q;
    assign md.LO       = lo_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (is_md) state_nx = BUSY;
            BUSY:    if (cnt == 4'd1) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Signed divide works on magnitudes so the most-negative / -1 case wraps to
    // 0x80000000 without relying on simulator overflow behaviour.
    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        prod   = 64'd0;
        mag_a  = md.A_E[31] ? (32'd0 - md.A_E) : md.A_E;
        mag_b  = md.B_E[31] ? (32'd0 - md.B_E) : md.B_E;
        quo    = 32'd0;
        rem    = 32'd0;
        case (md.md_op_E)
            OP_MULT: begin
                prod   = {{32{md.A_E[31]}}, md.A_E} * {{32{md.B_E[31]}}, md.B_E};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            OP_MULTU: begin
                prod   = {32'd0, md.A_E} * {32'd0, md.B_E};
                res_hi = prod[63:32];
                res_lo = prod[31:0];
            end
            OP_DIV: begin
                if (md.B_E != 32'd0) begin
                    quo    = mag_a / mag_b;
                    rem    = mag_a % mag_b;
                    res_lo = (md.A_E[31] ^ md.B_E[31]) ? (32'd0 - quo) : quo;
                    res_hi = md.A_E[31] ? (32'd0 - rem) : rem;
                end
            end
            OP_DIVU: begin
                if (md.B_E != 32'd0) begin
                    res_lo = md.A_E / md.B_E;
                    res_hi = md.A_E % md.B_E;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= 4'd0;
            hi_n <= 32'd0;
            lo_n <= 32'd0;
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_md) begin
                        hi_n <= res_hi;
                        lo_n <= res_lo;
                        cnt  <= (md.md_op_E <= OP_MULTU) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                    end else if (md.md_op_E == OP_MTHI) begin
                        hi_q <= md.A_E;
                    end else if (md.md_op_E == OP_MTLO) begin
                        lo_q <= md.A_E;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        hi_q <= hi_n;
                        lo_q <= lo_n;
                    end
                end
                default: cnt <= 4'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: hand-computed HI/LO results, busy window length,
// stall behaviour, ignored ops while busy and asynchronous reset abort.
module tb_md_sched;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    md_sched_if bus ();

    md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Present an op in E for one cycle and walk its busy window, checking
    // start/stall at launch, busy and stall every busy cycle, and drop afterward.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, input logic use_d);
        bus.md_op_E  = op;
        bus.A_E      = a;
        bus.B_E      = b;
        bus.md_use_D = use_d;
        #1;
        check("start_at_launch", 32'(bus.start), 32'd1);
        check("stall_at_launch", 32'(bus.stall_md), 32'(use_d));
        tick();
        bus.md_op_E = 3'd0;
        for (int i = 0; i < n; i++) begin
            check($sformatf("busy_cycle%0d", i + 1), 32'(bus.busy), 32'd1);
            check($sformatf("stall_cycle%0d", i + 1), 32'(bus.stall_md), 32'(use_d));
            tick();
        end
        check("busy_done", 32'(bus.busy), 32'd0);
        check("stall_done", 32'(bus.stall_md), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        bus.md_op_E  = 3'd0;
        bus.A_E      = 32'd0;
        bus.B_E      = 32'd0;
        bus.md_use_D = 1'b1;
        tick();
        tick();
        check("rst_hi", bus.HI, 32'd0);
        check("rst_lo", bus.LO, 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_stall", 32'(bus.stall_md), 32'd0);
        reset = 1'b1;
        tick();

        // mult -3 * 5 with a dependent instruction in D
        run_op(3'd1, 32'hFFFF_FFFD, 32'd5, 5, 1'b1);
        check("mult_hi", bus.HI, 32'hFFFF_FFFF);
        check("mult_lo", bus.LO, 32'hFFFF_FFF1);

        // divu 7 / 2, independent D instruction never stalls
        run_op(3'd4, 32'd7, 32'd2, 10, 1'b0);
        check("divu_lo", bus.LO, 32'd3);
        check("divu_hi", bus.HI, 32'd1);

        // div -7 / 2
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 10, 1'b1);
        check("div_lo", bus.LO, 32'hFFFF_FFFD);
        check("div_hi", bus.HI, 32'hFFFF_FFFF);

        // div most-negative / -1
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 1'b0);
        check("divovf_lo", bus.LO, 32'h8000_0000);
        check("divovf_hi", bus.HI, 32'd0);

        // mthi / mtlo
        bus.md_use_D = 1'b1;
        bus.md_op_E  = 3'd5;
        bus.A_E      = 32'h11;
        #1;
        check("mthi_no_start", 32'(bus.start), 32'd0);
        check("mthi_no_stall", 32'(bus.stall_md), 32'd0);
        tick();
        check("mthi_hi", bus.HI, 32'h11);
        check("mthi_busy", 32'(bus.busy), 32'd0);
        bus.md_op_E = 3'd6;
        bus.A_E     = 32'h22;
        tick();
        bus.md_op_E = 3'd0;
        check("mtlo_lo", bus.LO, 32'h22);
        check("mtlo_hi_kept", bus.HI, 32'h11);

        // divide by zero keeps HI/LO
        run_op(3'd3, 32'd5, 32'd0, 10, 1'b1);
        check("dz_hi", bus.HI, 32'h11);
        check("dz_lo", bus.LO, 32'h22);

        // mthi issued while busy is ignored; 0x10000 * 0x30000 = 0x3_0000_0000
        bus.md_op_E = 3'd1;
        bus.A_E     = 32'h0001_0000;
        bus.B_E     = 32'h0003_0000;
        tick();
        bus.md_op_E = 3'd0;
        tick();
        bus.md_op_E = 3'd5;
        bus.A_E     = 32'h0000_AAAA;
        #1;
        check("ign_no_start", 32'(bus.start), 32'd0);
        tick();
        bus.md_op_E = 3'd0;
        check("ign_hi_mid", bus.HI, 32'h11);
        check("ign_busy_mid", 32'(bus.busy), 32'd1);
        tick();
        tick();
        check("ign_busy_last", 32'(bus.busy), 32'd1);
        tick();
        check("ign_busy_done", 32'(bus.busy), 32'd0);
        check("ign_hi", bus.HI, 32'd3);
        check("ign_lo", bus.LO, 32'd0);

        // reset during div busy cycle 4
        bus.md_op_E = 3'd3;
        bus.A_E     = 32'd100;
        bus.B_E     = 32'd7;
        tick();
        bus.md_op_E = 3'd0;
        tick();
        tick();
        tick();
        check("abort_busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_hi", bus.HI, 32'd0);
        check("abort_lo", bus.LO, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("post_rst_busy", 32'(bus.busy), 32'd0);
        run_op(3'd2, 32'd3, 32'd4, 5, 1'b1);
        check("multu_lo", bus.LO, 32'd12);
        check("multu_hi", bus.HI, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide controller for the 5-stage MIPS pipeline; sits beside the EX stage.
- Accepts mult/multu/div/divu/mthi/mtlo from E and sequences a fixed-latency busy window.
- Owns the HI/LO registers.
- Produces the pipeline stall request for any D-stage instruction that touches HI/LO while the unit is starting or busy.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal 1..15)

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- md_op_E  input  3  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
- A_E  input  32  forwarded rs value in E
- B_E  input  32  forwarded rt value in E
- md_use_D  input  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- HI  output  32  HI register
- LO  output  32  LO register
- busy  output  1  unit computing
- start  output  1  combinational: md_op_E in 1..4 and state IDLE
- stall_md  output  1  combinational: md_use_D && (start || busy)

Behaviour:
- Reset (reset==0, asynchronous)
  - state=IDLE, cnt=0, busy=0, HI=0, LO=0; internal result regs cleared.
  - A reset mid-operation aborts the operation; HI/LO read 0 after reset.
- States: IDLE, BUSY. The 4-bit down-counter cnt is valid only in BUSY.
- IDLE, md_op_E=1..4 at clock edge e0
  - Latch the result into internal hi_n/lo_n.
  - cnt <= MULT_CYCLES or DIV_CYCLES; state <= BUSY; busy <= 1.
- BUSY
  - Each edge: cnt <= cnt-1.
  - On the edge where cnt==1: HI<=hi_n, LO<=lo_n, busy<=0, state<=IDLE.
  - Net effect: busy is high for exactly N cycles after e0, and the new HI/LO are visible from the cycle in which busy first reads 0.
- Arithmetic
  - mult: signed 32x32 -> 64; HI=prod[63:32], LO=prod[31:0].
  - multu: same, unsigned.
  - div: signed, quotient truncated toward zero -> LO; remainder takes the sign of the dividend -> HI.
  - divu: unsigned; LO=quotient, HI=remainder.
  - Divide by zero (B_E==0): unit still goes busy for DIV_CYCLES; HI/LO keep their prior values at completion.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo in IDLE: HI<=A_E (mthi) or LO<=A_E (mtlo) at the next edge; no busy.
- Any md_op_E while BUSY: ignored; no state, counter, HI or LO change. Normal pipeline operation never does this because stall_md holds the instruction in D.
- mfhi/mflo read HI/LO directly, with no internal bypass.
- Stall timing
  - stall_md is asserted in the cycle the op sits in E (via start) and through every busy cycle.
  - It is never asserted when md_use_D=0; independent instructions keep flowing.
- No flush input: a started operation always completes unless reset.

Test Plan:
- Reset low, then high; md_op_E=1, A=0xFFFFFFFD, B=5 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFF1; busy and HI/LO updates coincide exactly.
- md_op_E=4, A=7, B=2 -> busy 10 cycles, then LO=3, HI=1. Repeat with md_op_E=3, A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- md_op_E=3, B=0 with HI=0x11, LO=0x22 preset via mthi/mtlo -> busy 10 cycles, HI=0x11, LO=0x22 unchanged.
- Start mult; in busy cycle 2 drive md_op_E=5, A=0xAAAA -> ignored; final HI equals the product high word, not 0xAAAA.
- md_use_D=1 during start and busy -> stall_md=1 for 1+N cycles, then 0. md_use_D=0 in the same window -> stall_md=0 throughout.
- Start div, then pull reset low at busy cycle 4 -> busy=0, HI=LO=0 immediately; after release the unit is idle and a new multu (3x4) gives LO=12.
